// File: rtl/osc_pkg.sv
// Shared types and helpers for the waveform oscillator bank.
package osc_pkg;

  // Channel operating mode; code 3 is reserved and behaves like MODE_OFF.
  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_SQUARE = 2'd1,
    MODE_PULSE  = 2'd2
  } osc_mode_e;

  // Clamp a wide signed value into the signed range of 'width' bits.
  // Callers sign-extend into 64 bits and truncate the result back down.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                  input int unsigned        width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (value > max_v) return max_v;
    if (value < min_v) return min_v;
    return value;
  endfunction

endpackage

// File: rtl/waveform_osc_bank_if.sv
// Configuration bus shared by every oscillator channel.
interface waveform_osc_bank_if #(
  parameter int CH_W     = 2,
  parameter int COUNT_W  = 32,
  parameter int SAMPLE_W = 24
);
  logic                       cfg_we;
  logic [CH_W-1:0]            cfg_ch;
  logic [1:0]                 cfg_mode;
  logic [COUNT_W-1:0]         cfg_period;
  logic [COUNT_W-1:0]         cfg_duty;
  logic signed [SAMPLE_W-1:0] cfg_amp;
  logic                       sync;

  modport master (
    output cfg_we, cfg_ch, cfg_mode, cfg_period, cfg_duty, cfg_amp, sync
  );

  modport slave (
    input cfg_we, cfg_ch, cfg_mode, cfg_period, cfg_duty, cfg_amp, sync
  );
endinterface

// File: rtl/osc_channel.sv
// One oscillator channel: config registers, phase counter, registered
// sample and polarity-change pulse.
module osc_channel
  import osc_pkg::*;
#(
  parameter int SAMPLE_W = 24,
  parameter int COUNT_W  = 32,
  parameter int CH_W     = 2,
  parameter int IDX      = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  waveform_osc_bank_if.slave         cfg,
  output logic signed [SAMPLE_W-1:0] sample,
  output logic                       pol_edge
);

  logic [1:0]                 mode_d, mode_q;
  logic [COUNT_W-1:0]         period_d, period_q;
  logic [COUNT_W-1:0]         duty_d, duty_q;
  logic [COUNT_W-1:0]         cnt_d, cnt_q;
  logic signed [SAMPLE_W-1:0] amp_d, amp_q;
  logic signed [SAMPLE_W-1:0] sample_d, sample_q;
  logic                       pol_edge_d, pol_edge_q;

  logic                       sel;
  logic                       active;
  logic                       high;
  logic                       pos_d, pos_q;
  logic [COUNT_W-1:0]         thr;
  logic signed [SAMPLE_W:0]   amp_neg_wide;
  logic signed [SAMPLE_W-1:0] amp_neg;

  assign sel = cfg.cfg_we && (cfg.cfg_ch == CH_W'(IDX));

  // Load all config fields when this channel is addressed.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    mode_d   = mode_q;
    period_d = period_q;
    duty_d   = duty_q;
    amp_d    = amp_q;
    if (sel) begin
      mode_d   = cfg.cfg_mode;
      period_d = cfg.cfg_period;
      duty_d   = cfg.cfg_duty;
      amp_d    = cfg.cfg_amp;
    end
  end

  // Phase counter: wraps at period-1, restarts on a config write or sync.
  always_comb begin
    cnt_d = cnt_q + COUNT_W'(1);
    if (sel || cfg.sync) begin
      cnt_d = '0;
    end else if (period_q < COUNT_W'(2)) begin
      cnt_d = '0;
    end else if (cnt_q >= period_q - COUNT_W'(1)) begin
      cnt_d = '0;
    end
  end

  // Sample from the current phase; -amp is formed one bit wider so the most
  // negative amplitude clamps to the most positive code instead of wrapping.
  always_comb begin
    active       = ((mode_q == MODE_SQUARE) || (mode_q == MODE_PULSE)) && (period_q != '0);
    thr          = (mode_q == MODE_SQUARE) ? (period_q >> 1) : duty_q;
    high         = cnt_q < thr;
    amp_neg_wide = -{amp_q[SAMPLE_W-1], amp_q};
    amp_neg      = SAMPLE_W'(saturate({{(63-SAMPLE_W){amp_neg_wide[SAMPLE_W]}}, amp_neg_wide},
                                      SAMPLE_W));
    sample_d     = '0;
    if (active) sample_d = high ? amp_q : amp_neg;
    pos_d        = !sample_d[SAMPLE_W-1] && (sample_d != '0);
    pos_q        = !sample_q[SAMPLE_W-1] && (sample_q != '0);
    pol_edge_d   = pos_d ^ pos_q;
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (!rst_n) begin
      mode_q     <= MODE_OFF;
      period_q   <= '0;
      duty_q     <= '0;
      amp_q      <= '0;
      cnt_q      <= '0;
      sample_q   <= '0;
      pol_edge_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      period_q   <= period_d;
      duty_q     <= duty_d;
      amp_q      <= amp_d;
      cnt_q      <= cnt_d;
      sample_q   <= sample_d;
      pol_edge_q <= pol_edge_d;
    end
  end

  assign sample   = sample_q;
  assign pol_edge = pol_edge_q;

endmodule

// File: rtl/waveform_osc_bank.sv
// Bank of independent square/pulse oscillators with a saturating mixer.
module waveform_osc_bank
  import osc_pkg::*;
#(
  parameter int  CHANNELS = 4,
  parameter int  SAMPLE_W = 24,
  parameter int  COUNT_W  = 32,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_we,
  input  logic [CH_W-1:0]              cfg_ch,
  input  logic [1:0]                   cfg_mode,
  input  logic [COUNT_W-1:0]           cfg_period,
  input  logic [COUNT_W-1:0]           cfg_duty,
  input  logic signed [SAMPLE_W-1:0]   cfg_amp,
  input  logic                         sync,
  output logic [CHANNELS*SAMPLE_W-1:0] ch_out,
  output logic [CHANNELS-1:0]          ch_edge,
  output logic signed [SAMPLE_W-1:0]   mix_out
);

  localparam int SUM_W = SAMPLE_W + CH_W;

  waveform_osc_bank_if #(
    .CH_W    (CH_W),
    .COUNT_W (COUNT_W),
    .SAMPLE_W(SAMPLE_W)
  ) cfg_bus ();

  assign cfg_bus.cfg_we     = cfg_we;
  assign cfg_bus.cfg_ch     = cfg_ch;
  assign cfg_bus.cfg_mode   = cfg_mode;
  assign cfg_bus.cfg_period = cfg_period;
  assign cfg_bus.cfg_duty   = cfg_duty;
  assign cfg_bus.cfg_amp    = cfg_amp;
  assign cfg_bus.sync       = sync;

  logic signed [SAMPLE_W-1:0] samples [CHANNELS];
  logic [CHANNELS-1:0]        edges;

  // Channel indices at or above CHANNELS match no instance, so such writes drop.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    osc_channel #(
      .SAMPLE_W(SAMPLE_W),
      .COUNT_W (COUNT_W),
      .CH_W    (CH_W),
      .IDX     (i)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .cfg     (cfg_bus),
      .sample  (samples[i]),
      .pol_edge(edges[i])
    );
    assign ch_out[i*SAMPLE_W +: SAMPLE_W] = samples[i];
  end

  assign ch_edge = edges;

  logic signed [SUM_W-1:0]    sum;
  logic signed [SAMPLE_W-1:0] mix_d, mix_q;

  // Sum in SUM_W bits (cannot overflow for up to 2^CH_W channels), then clamp.
  always_comb begin
    sum = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sum = sum + {{CH_W{samples[i][SAMPLE_W-1]}}, samples[i]};
    end
    mix_d = SAMPLE_W'(saturate({{(64-SUM_W){sum[SUM_W-1]}}, sum}, SAMPLE_W));
  end

  // Mixer output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mix_q <= '0;
    else        mix_q <= mix_d;
  end

  assign mix_out = mix_q;

endmodule

// File: tb/tb_waveform_osc_bank.sv
// Scoreboard bench for waveform_osc_bank: stimulus pushes per-cycle expected
// outputs, a negedge monitor pops and compares them.
module tb_waveform_osc_bank;

  logic clk;
  logic rst_n;
  int   cyc;

  waveform_osc_bank_if #(.CH_W(2), .COUNT_W(32), .SAMPLE_W(24)) bus  ();
  waveform_osc_bank_if #(.CH_W(2), .COUNT_W(32), .SAMPLE_W(24)) bus3 ();

  logic [4*24-1:0]    ch_out;
  logic [3:0]         ch_edge;
  logic signed [23:0] mix_out;
  logic [3*24-1:0]    ch_out3;
  logic [2:0]         ch_edge3;
  logic signed [23:0] mix_out3;

  waveform_osc_bank #(.CHANNELS(4), .SAMPLE_W(24), .COUNT_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (bus.cfg_we),
    .cfg_ch    (bus.cfg_ch),
    .cfg_mode  (bus.cfg_mode),
    .cfg_period(bus.cfg_period),
    .cfg_duty  (bus.cfg_duty),
    .cfg_amp   (bus.cfg_amp),
    .sync      (bus.sync),
    .ch_out    (ch_out),
    .ch_edge   (ch_edge),
    .mix_out   (mix_out)
  );

  // Three-channel copy so that an out-of-range index (3) is representable.
  waveform_osc_bank #(.CHANNELS(3), .SAMPLE_W(24), .COUNT_W(32)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (bus3.cfg_we),
    .cfg_ch    (bus3.cfg_ch),
    .cfg_mode  (bus3.cfg_mode),
    .cfg_period(bus3.cfg_period),
    .cfg_duty  (bus3.cfg_duty),
    .cfg_amp   (bus3.cfg_amp),
    .sync      (bus3.sync),
    .ch_out    (ch_out3),
    .ch_edge   (ch_edge3),
    .mix_out   (mix_out3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     cyc;
    int     sel;
    longint exp;
  } exp_t;

  // One entry per configuration epoch of a main-DUT channel; 'start' is the
  // first cycle whose ch_out reflects phase 0 of that epoch.
  typedef struct {
    int     ch;
    int     start;
    int     mode;
    longint period;
    longint duty;
    longint amp;
  } ent_t;

  exp_t sb[$];
  ent_t hist[$];
  int   n_pass;
  int   n_total;

  task automatic check(input string name, input int c, input longint act, input longint exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d, expected %0d", name, c, act, exp);
  endtask

  function automatic longint sx(input logic [23:0] x);
    return longint'($signed(x));
  endfunction

  function automatic string sel_name(input int sel);
    case (sel)
      0, 1, 2, 3: return $sformatf("ch_out%0d", sel);
      4:          return "mix_out";
      5:          return "ch_edge";
      6, 7, 8:    return $sformatf("dut3_ch_out%0d", sel - 6);
      9:          return "dut3_mix_out";
      default:    return "dut3_ch_edge";
    endcase
  endfunction

  function automatic longint actual(input int sel);
    case (sel)
      0, 1, 2, 3: return sx(ch_out[sel*24 +: 24]);
      4:          return sx(mix_out);
      5:          return longint'(ch_edge);
      6, 7, 8:    return sx(ch_out3[(sel-6)*24 +: 24]);
      9:          return sx(mix_out3);
      default:    return longint'(ch_edge3);
    endcase
  endfunction

  // Independent reference for one channel's sample at cycle c.
  function automatic longint model(input int i, input int c);
    ent_t   e;
    bit     found;
    longint ph;
    longint thr;
    found = 1'b0;
    for (int k = hist.size() - 1; k >= 0; k--) begin
      if (!found && hist[k].ch == i && hist[k].start <= c) begin
        e     = hist[k];
        found = 1'b1;
      end
    end
    if (!found) return 0;
    if (!(e.mode == 1 || e.mode == 2) || e.period == 0) return 0;
    ph  = (e.period <= 1) ? 0 : longint'(c - e.start) % e.period;
    thr = (e.mode == 1) ? e.period / 2 : e.duty;
    if (ph < thr) return e.amp;
    return (e.amp == -8388608) ? 8388607 : -e.amp;
  endfunction

  function automatic ent_t latest(input int i);
    ent_t e;
    e = '{i, 0, 0, 0, 0, 0};
    for (int k = 0; k < hist.size(); k++) if (hist[k].ch == i) e = hist[k];
    return e;
  endfunction

  task automatic push(input int c, input int sel, input longint exp);
    exp_t e;
    e = '{c, sel, exp};
    sb.push_back(e);
  endtask

  // Expected outputs for cycles c0..c1: samples, edges vs previous cycle,
  // saturated mix of the previous cycle's samples; dut3 is always silent.
  task automatic push_window(input int c0, input int c1);
    longint v, vp, sum;
    logic [3:0] edg;
    for (int c = c0; c <= c1; c++) begin
      sum = 0;
      edg = '0;
      for (int i = 0; i < 4; i++) begin
        v   = model(i, c);
        vp  = model(i, c - 1);
        sum = sum + vp;
        edg[i] = (v > 0) != (vp > 0);
        push(c, i, v);
      end
      if (sum > 8388607)  sum = 8388607;
      if (sum < -8388608) sum = -8388608;
      push(c, 4, sum);
      push(c, 5, longint'(edg));
      for (int s = 6; s <= 10; s++) push(c, s, 0);
    end
  endtask

  // Monitor: compare every expectation due at this cycle.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc != cyc) check({"missed_", sel_name(e.sel)}, cyc, longint'(cyc), longint'(e.cyc));
      else              check(sel_name(e.sel), cyc, actual(e.sel), e.exp);
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int ch, input int mode, input longint period,
                          input longint duty, input longint amp);
    ent_t e;
    next_cyc();
    bus.cfg_we     = 1'b1;
    bus.cfg_ch     = 2'(ch);
    bus.cfg_mode   = 2'(mode);
    bus.cfg_period = 32'(period);
    bus.cfg_duty   = 32'(duty);
    bus.cfg_amp    = 24'(amp);
    e = '{ch, cyc + 2, mode, period, duty, amp};
    hist.push_back(e);
    next_cyc();
    bus.cfg_we = 1'b0;
  endtask

  task automatic do_write3(input int ch, input int mode, input longint period,
                           input longint amp);
    next_cyc();
    bus3.cfg_we     = 1'b1;
    bus3.cfg_ch     = 2'(ch);
    bus3.cfg_mode   = 2'(mode);
    bus3.cfg_period = 32'(period);
    bus3.cfg_duty   = '0;
    bus3.cfg_amp    = 24'(amp);
    next_cyc();
    bus3.cfg_we = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && sb.size() != 0; k++) @(posedge clk);
    if (sb.size() != 0) begin
      check("drain_pending", cyc, longint'(sb.size()), 0);
      sb.delete();
    end
    next_cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle %0d: got timeout, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   s_cyc;
    int   r_cyc;
    ent_t e;
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_mode = '0; bus.cfg_period = '0;
    bus.cfg_duty = '0; bus.cfg_amp = '0; bus.sync = 1'b0;
    bus3.cfg_we = 1'b0; bus3.cfg_ch = '0; bus3.cfg_mode = '0; bus3.cfg_period = '0;
    bus3.cfg_duty = '0; bus3.cfg_amp = '0; bus3.sync = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e = '{i, -1000000, 0, 0, 0, 0};
      hist.push_back(e);
    end

    // Reset state and idle outputs after release.
    repeat (3) next_cyc();
    rst_n = 1'b1;
    push_window(cyc + 1, cyc + 5);
    drain();

    // SQUARE period 8 amp 1000: 4 high, 4 low, edge every 4 cycles.
    do_write(0, 1, 8, 0, 1000);
    push_window(cyc + 1, cyc + 17);
    drain();

    // PULSE period 10 duty 3 amp 500; then duty 12 (all high), duty 0 (all low).
    do_write(0, 2, 10, 3, 500);
    push_window(cyc + 1, cyc + 21);
    drain();
    do_write(0, 2, 10, 12, 500);
    push_window(cyc + 1, cyc + 13);
    drain();
    do_write(0, 2, 10, 0, 500);
    push_window(cyc + 1, cyc + 13);
    drain();

    // Most negative amplitude: low phase must clamp to +8388607.
    do_write(0, 1, 4, 0, -8388608);
    push_window(cyc + 1, cyc + 9);
    drain();

    // Four channels at 2^22: mix saturates high, then low.
    for (int i = 0; i < 4; i++) do_write(i, 2, 10, 10, 4194304);
    push_window(cyc + 1, cyc + 6);
    drain();
    for (int i = 0; i < 4; i++) do_write(i, 2, 10, 0, 4194304);
    push_window(cyc + 1, cyc + 6);
    drain();

    // Sync mid-period on periods 6 and 10, together with a write to ch3;
    // a later write to ch2 must not disturb ch0/ch1 phase.
    do_write(0, 1, 6, 0, 100);
    do_write(1, 1, 10, 0, 200);
    do_write(2, 0, 0, 0, 0);
    do_write(3, 0, 0, 0, 0);
    repeat (4) next_cyc();
    next_cyc();
    s_cyc          = cyc;
    bus.sync       = 1'b1;
    bus.cfg_we     = 1'b1;
    bus.cfg_ch     = 2'd3;
    bus.cfg_mode   = 2'd2;
    bus.cfg_period = 32'd10;
    bus.cfg_duty   = 32'd10;
    bus.cfg_amp    = 24'd300;
    for (int i = 0; i < 4; i++) begin
      e       = latest(i);
      e.start = s_cyc + 2;
      hist.push_back(e);
    end
    e = '{3, s_cyc + 2, 2, 10, 10, 300};
    hist.push_back(e);
    push_window(s_cyc + 1, s_cyc + 6);
    next_cyc();
    bus.sync   = 1'b0;
    bus.cfg_we = 1'b0;
    repeat (3) next_cyc();
    do_write(2, 1, 4, 0, 50);
    push_window(s_cyc + 7, s_cyc + 18);
    drain();

    // Asynchronous reset mid-run, then ignored out-of-range and reserved-mode writes.
    repeat (3) next_cyc();
    r_cyc = cyc;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e = '{i, r_cyc, 0, 0, 0, 0};
      hist.push_back(e);
    end
    for (int s = 0; s <= 10; s++) push(r_cyc, s, 0);
    push_window(r_cyc + 1, r_cyc + 14);
    repeat (2) next_cyc();
    rst_n = 1'b1;
    do_write3(3, 1, 4, 100);
    do_write3(0, 3, 4, 100);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
